cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
// - Common Data Bus (CDB) arbiter for the Tomasulo core.
// - Functional units (ALU, MUL, LD/ST) complete out of order and request the single CDB.
// - The block grants one requester per cycle, round-robin, and registers the winning tag and result onto the CDB.
// - The CDB feeds the reservation stations and the register status table.
// PARAMETERS
// - NUM_REQ  4   number of functional-unit requesters (>=2)
// - TAG_W    4   reservation-station tag width; tag 0 = "no producer"
// - DATA_W   32  result width
// - CNT_W    16  broadcast performance counter width
// PORTS
// - clk        in   1                sole clock, rising edge
// - reset      in   1                asynchronous, active-low reset
// - req_valid  in   NUM_REQ          FU i holds a completed result
// - req_tag    in   NUM_REQ*TAG_W    tag of FU i, slice [i*TAG_W +: TAG_W]
// - req_data   in   NUM_REQ*DATA_W   result of FU i, slice [i*DATA_W +: DATA_W]
// - req_ready  out  NUM_REQ          one-hot grant; transfer when valid&ready
// - cdb_hold   in   1                downstream stall: no grant this cycle
// - cdb_valid  out  1                broadcast valid
// - cdb_tag    out  TAG_W            broadcast tag
// - cdb_data   out  DATA_W           broadcast value
// - cdb_src    out  $clog2(NUM_REQ)  index of the granted FU
// - cdb_count  out  CNT_W            total broadcasts, wraps
// BEHAVIOUR
// - Reset (reset=0, async):
//   - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, cdb_count=0.
//   - RR pointer=0. req_ready is 0 while reset is low.
// - Grant (combinational, same cycle):
//   - req_ready is at most one-hot.
//   - No requester is granted when cdb_hold=1 or no req_valid is set.
//   - Otherwise the first i with req_valid[i]=1 is granted, scanning ptr, ptr+1, ... mod NUM_REQ.
//   - req_ready[i]=1 is never asserted while req_valid[i]=0.
// - Handshake: FU i holds valid/tag/data stable until the cycle it sees req_ready[i]=1. It may drop valid only after the transfer.
// - Pointer: after a transfer from i, ptr <= (i+1) mod NUM_REQ. ptr is unchanged on idle and hold cycles.
// - Broadcast latency is 1 cycle:
//   - A transfer at edge N drives cdb_valid/tag/data/src at N+1 for exactly one cycle.
//   - cdb_valid=0 in the cycle after a cycle with no transfer.
//   - cdb_tag and cdb_data keep their last values when cdb_valid=0.
// - Back-to-back: one transfer per cycle sustained; no bubble between grants.
// - cdb_count increments by 1 per transfer, modulo 2^CNT_W; 2^CNT_W-1 -> 0.
// - Simultaneous events:
//   - cdb_hold=1 with all valid: no grant, ptr held, cdb_valid=0 next cycle.
//   - A request arriving in the same cycle as the pointer moves is eligible immediately.
// - Reset mid-broadcast: outputs clear asynchronously. Any in-flight result is lost; the FU still sees no ready and retries after reset.
// - No fairness beyond RR is required: worst-case wait is NUM_REQ-1 grants while cdb_hold=0.
// STRUCTURE
// - Package tomasulo_pkg holds:
//   - TAG_W and DATA_W constants, and NO_TAG = '0.
//   - typedef cdb_t {logic valid; logic [TAG_W-1:0] tag; logic [DATA_W-1:0] data;}.
//   - RS and FU counts.
// - Sub-module rr_arbiter #(N): inputs req[N], en, ptr; outputs onehot grant and grant_idx. Purely combinational, double-vector priority scan.
// - cdb_arbiter holds the ptr register, the CDB output register and the counter.
// TESTING
// - Reset: pulse reset=0 asynchronously mid-cycle -> all outputs 0 immediately, ptr=0, req_ready=0.
// - Single request, FU2 tag=3 data=32'hDEADBEEF:
//   - req_ready=4'b0100 same cycle.
//   - Next cycle cdb_valid=1, tag=3, data=DEADBEEF, src=2, cdb_count=1.
//   - Then ptr=3.
// - Rotation, all 4 valid and held for 4 cycles from ptr=0:
//   - Grants 0,1,2,3 in order, no bubble.
//   - cdb_valid=1 for 4 consecutive cycles; cdb_count=4.
// - Hold: all valid, cdb_hold=1 for 2 cycles:
//   - req_ready=0 and cdb_valid=0 during the hold, ptr unchanged.
//   - On release, the grant goes to ptr.
// - Sparse, ptr=3, valid=4'b0011: grant FU0, next grant FU1, then ptr=2.
// - Counter wrap, CNT_W=4: 17 transfers -> cdb_count=1.
// - Assertions throughout: req_ready onehot0, and req_ready implies req_valid.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core constants and the CDB broadcast record.
package tomasulo_pkg;

  localparam int unsigned TAG_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned NUM_RS = 8;
  localparam int unsigned NUM_FU = 4;

  // Tag value meaning "no producer" in the register status table.
  localparam logic [TAG_W-1:0] NO_TAG = '0;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr wins, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic            en,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] grant_idx
);

  logic [N-1:0]   mask;
  logic [2*N-1:0] req_dbl;
  logic           found;

  always_comb begin
    mask = '0;
    for (int k = 0; k < N; k++) begin
      mask[k] = (k >= int'(ptr));
    end
  end

  // Low half holds requests at or above ptr, high half the wrapped-around set.
  assign req_dbl = {req, req & mask};

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int j = 0; j < 2 * N; j++) begin
      if (!found && en && req_dbl[j]) begin
        found     = 1'b1;
        grant_idx = (j >= N) ? IdxW'(j - N) : IdxW'(j);
      end
    end
    if (found) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin grant among functional units and a
// registered one-cycle broadcast of the winning tag/result.
module cdb_arbiter #(
  parameter int unsigned NUM_REQ = tomasulo_pkg::NUM_FU,
  parameter int unsigned TAG_W   = tomasulo_pkg::TAG_W,
  parameter int unsigned DATA_W  = tomasulo_pkg::DATA_W,
  parameter int unsigned CNT_W   = tomasulo_pkg::CNT_W,
  localparam int unsigned SRC_W  = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      cdb_hold,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [SRC_W-1:0]          cdb_src,
  output logic [CNT_W-1:0]          cdb_count
);

  logic [SRC_W-1:0]  ptr_q, ptr_d;
  logic              valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SRC_W-1:0]  src_q, src_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              grant_en;
  logic [SRC_W-1:0]  grant_idx;
  logic              xfer;

  // Grants are suppressed while reset is held so no FU believes it transferred.
  assign grant_en = reset & ~cdb_hold;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr_arbiter (
    .req       (req_valid),
    .en        (grant_en),
    .ptr       (ptr_q),
    .grant     (req_ready),
    .grant_idx (grant_idx)
  );

  assign xfer = |req_ready;

  always_comb begin
    ptr_d   = ptr_q;
    valid_d = 1'b0;
    tag_d   = tag_q;
    data_d  = data_q;
    src_d   = src_q;
    count_d = count_q;
    if (xfer) begin
      valid_d = 1'b1;
      tag_d   = req_tag[grant_idx*TAG_W +: TAG_W];
      data_d  = req_data[grant_idx*DATA_W +: DATA_W];
      src_d   = grant_idx;
      count_d = count_q + CNT_W'(1);
      ptr_d   = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
      src_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      src_q   <= src_d;
      count_q <= count_d;
    end
  end

  assign cdb_valid = valid_q;
  assign cdb_tag   = tag_q;
  assign cdb_data  = data_q;
  assign cdb_src   = src_q;
  assign cdb_count = count_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: reset sequence, directed vector table, then random traffic
// checked against a behavioural round-robin model.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int TW = 4;
  localparam int DW = 32;
  localparam int CW = 4;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            cdb_hold;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic [1:0]      cdb_src;
  logic [CW-1:0]   cdb_count;

  int n_vec = 0;
  int n_err = 0;

  cdb_arbiter #(
    .NUM_REQ (N),
    .TAG_W   (TW),
    .DATA_W  (DW),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb_hold  (cdb_hold),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src),
    .cdb_count (cdb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Structural grant properties, sampled mid-cycle.
  always @(negedge clk) begin
    chk("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
    chk("ready_implies_valid", 64'(req_ready & ~req_valid), 64'd0);
  end

  typedef struct packed {
    logic [3:0] valid;
    logic       hold;
    logic [3:0] rdy;
    logic       cv;
    logic [1:0] src;
    logic [3:0] cnt;
  } vec_t;

  vec_t            tbl [20];
  logic [TW-1:0]   tag_tab  [N];
  logic [DW-1:0]   data_tab [N];

  // Random-phase FU state and reference model.
  logic            fu_valid [N];
  logic [TW-1:0]   fu_tag   [N];
  logic [DW-1:0]   fu_data  [N];
  int              m_ptr, m_count, m_src, g;
  logic            m_valid;
  logic [TW-1:0]   m_tag;
  logic [DW-1:0]   m_data;
  logic [N-1:0]    exp_rdy;

  task automatic drive_fu();
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = fu_valid[i];
      req_tag[i*TW +: TW]    = fu_tag[i];
      req_data[i*DW +: DW]   = fu_data[i];
    end
  endtask

  initial begin
    tag_tab  = '{4'd1, 4'd2, 4'd3, 4'd4};
    data_tab = '{32'h1000_0000, 32'h1000_0001, 32'hDEAD_BEEF, 32'h1000_0003};
    //           valid    hold  rdy      cv    src   cnt
    tbl[0]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 4'd1};
    tbl[1]  = '{4'b0011, 1'b0, 4'b0001, 1'b1, 2'd0, 4'd2};
    tbl[2]  = '{4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 4'd3};
    tbl[3]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1, 4'd3};
    tbl[4]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 4'd4};
    tbl[5]  = '{4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, 4'd5};
    tbl[6]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 4'd6};
    tbl[7]  = '{4'b1111, 1'b0, 4'b0010, 1'b1, 2'd1, 4'd7};
    tbl[8]  = '{4'b1111, 1'b0, 4'b0100, 1'b1, 2'd2, 4'd8};
    tbl[9]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3, 4'd9};
    tbl[10] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd3, 4'd9};
    tbl[11] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd3, 4'd9};
    tbl[12] = '{4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 4'd10};
    tbl[13] = '{4'b1111, 1'b0, 4'b0010, 1'b1, 2'd1, 4'd11};
    tbl[14] = '{4'b1111, 1'b0, 4'b0100, 1'b1, 2'd2, 4'd12};
    tbl[15] = '{4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3, 4'd13};
    tbl[16] = '{4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 4'd14};
    tbl[17] = '{4'b1111, 1'b0, 4'b0010, 1'b1, 2'd1, 4'd15};
    tbl[18] = '{4'b1111, 1'b0, 4'b0100, 1'b1, 2'd2, 4'd0};
    tbl[19] = '{4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3, 4'd1};

    reset     = 1'b0;
    req_valid = '0;
    req_tag   = '0;
    req_data  = '0;
    cdb_hold  = 1'b0;
    #12 reset = 1'b1;
    @(posedge clk); #1;

    // One transfer from FU1 so ptr and outputs are non-zero before reset.
    req_valid = 4'b0010;
    req_tag   = 16'h0050;
    req_data  = {32'h0, 32'h0, 32'h0000_0055, 32'h0};
    @(negedge clk);
    chk("pre_reset_ready", 64'(req_ready), 64'b0010);
    @(posedge clk); #1;
    chk("pre_reset_valid", 64'(cdb_valid), 64'd1);
    chk("pre_reset_src", 64'(cdb_src), 64'd1);
    req_valid = 4'b1111;
    #2 reset = 1'b0;
    #1;
    chk("rst_valid", 64'(cdb_valid), 64'd0);
    chk("rst_tag", 64'(cdb_tag), 64'd0);
    chk("rst_data", 64'(cdb_data), 64'd0);
    chk("rst_src", 64'(cdb_src), 64'd0);
    chk("rst_count", 64'(cdb_count), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    #3 reset = 1'b1;
    // ptr must be back at 0: FU1 wins over FU3.
    req_valid = 4'b1010;
    #1 chk("rst_ptr_zero", 64'(req_ready), 64'b0010);
    req_valid = '0;
    @(posedge clk); #1;
    chk("idle_after_reset", 64'(cdb_valid), 64'd0);

    for (int i = 0; i < N; i++) begin
      req_tag[i*TW +: TW]  = tag_tab[i];
      req_data[i*DW +: DW] = data_tab[i];
    end
    for (int r = 0; r < 20; r++) begin
      req_valid = tbl[r].valid;
      cdb_hold  = tbl[r].hold;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", r), 64'(req_ready), 64'(tbl[r].rdy));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_cvalid", r), 64'(cdb_valid), 64'(tbl[r].cv));
      chk($sformatf("tbl%0d_src", r), 64'(cdb_src), 64'(tbl[r].src));
      chk($sformatf("tbl%0d_count", r), 64'(cdb_count), 64'(tbl[r].cnt));
      chk($sformatf("tbl%0d_tag", r), 64'(cdb_tag), 64'(tag_tab[tbl[r].src]));
      chk($sformatf("tbl%0d_data", r), 64'(cdb_data), 64'(data_tab[tbl[r].src]));
    end

    // Random traffic; state carried over from the last table row.
    m_ptr   = 0;
    m_count = 1;
    m_src   = 3;
    m_valid = 1'b1;
    m_tag   = tag_tab[3];
    m_data  = data_tab[3];
    for (int i = 0; i < N; i++) begin
      fu_valid[i] = 1'b0;
      fu_tag[i]   = '0;
      fu_data[i]  = '0;
    end
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!fu_valid[i] && ($urandom_range(1, 0) == 1)) begin
          fu_valid[i] = 1'b1;
          fu_tag[i]   = TW'($urandom);
          fu_data[i]  = $urandom;
        end
      end
      cdb_hold = ($urandom_range(4, 0) == 0);
      drive_fu();
      g = -1;
      if (!cdb_hold) begin
        for (int k = N - 1; k >= 0; k--) begin
          if (fu_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
      end
      exp_rdy = (g >= 0) ? N'(1 << g) : '0;
      @(negedge clk);
      chk("rnd_ready", 64'(req_ready), 64'(exp_rdy));
      @(posedge clk); #1;
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_tag       = fu_tag[g];
        m_data      = fu_data[g];
        m_src       = g;
        m_ptr       = (g + 1) % N;
        m_count     = (m_count + 1) % (1 << CW);
        fu_valid[g] = 1'b0;
      end
      chk("rnd_cvalid", 64'(cdb_valid), 64'(m_valid));
      chk("rnd_tag", 64'(cdb_tag), 64'(m_tag));
      chk("rnd_data", 64'(cdb_data), 64'(m_data));
      chk("rnd_src", 64'(cdb_src), 64'(m_src));
      chk("rnd_count", 64'(cdb_count), 64'(m_count));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
